// File: rtl/blink_divider_bank.sv
// Bank of independent programmable divider / LED-pattern channels sharing one clock.
// Each channel runs OFF, TOGGLE, PULSE or PWM from a wrap counter; the config port
// commits immediately to idle channels and at the next wrap for running ones.
module blink_divider_bank #(
    parameter int unsigned  CHANNELS       = 4,
    parameter int unsigned  CNT_W          = 25,
    parameter int unsigned  DEFAULT_PERIOD = 23_999_999,
    parameter int unsigned  OUT_INVERT     = 1,
    localparam int unsigned CH_W           = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [CHANNELS-1:0] enable,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [1:0]          cfg_mode,
    input  logic [CNT_W-1:0]    cfg_period,
    input  logic [CNT_W-1:0]    cfg_duty,
    output logic [CHANNELS-1:0] out,
    output logic [CHANNELS-1:0] tick
);

    typedef enum logic [1:0] {
        MODE_OFF    = 2'd0,
        MODE_TOGGLE = 2'd1,
        MODE_PULSE  = 2'd2,
        MODE_PWM    = 2'd3
    } mode_e;

    localparam logic INV = (OUT_INVERT != 0);

    logic [CNT_W-1:0] count     [CHANNELS];
    logic [CNT_W-1:0] period    [CHANNELS];
    logic [CNT_W-1:0] duty      [CHANNELS];
    logic [CNT_W-1:0] sh_period [CHANNELS];
    logic [CNT_W-1:0] sh_duty   [CHANNELS];
    mode_e            mode      [CHANNELS];
    mode_e            sh_mode   [CHANNELS];

    logic [CHANNELS-1:0] ff;
    logic [CHANNELS-1:0] pending;
    logic [CHANNELS-1:0] hit;
    logic [CHANNELS-1:0] running;
    logic [CHANNELS-1:0] wrap;
    logic [CHANNELS-1:0] accept;
    logic [CHANNELS-1:0] raw_c;
    mode_e               cfg_mode_e;

    assign cfg_mode_e = mode_e'(cfg_mode);

    // Per-channel run/wrap status, config routing and the raw pattern for the next cycle.
    always_comb begin
        hit       = '0;
        running   = '0;
        wrap      = '0;
        raw_c     = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            hit[i]     = (cfg_ch == CH_W'(i));
            running[i] = enable[i] && (mode[i] != MODE_OFF);
            wrap[i]    = running[i] && (count[i] == period[i]);
            if (running[i]) begin
                case (mode[i])
                    MODE_TOGGLE: raw_c[i] = ff[i] ^ wrap[i];
                    MODE_PULSE:  raw_c[i] = wrap[i];
                    MODE_PWM:    raw_c[i] = (count[i] < duty[i]);
                    default:     raw_c[i] = 1'b0;
                endcase
            end
        end
        // Out-of-range channel numbers hit nothing, so they are always ready and ignored.
        cfg_ready = ~|(hit & pending);
        accept    = hit & {CHANNELS{cfg_valid & cfg_ready}};
    end

    // Counters, pattern state, config commit/shadow and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                count[i]     <= '0;
                mode[i]      <= MODE_TOGGLE;
                period[i]    <= CNT_W'(DEFAULT_PERIOD);
                duty[i]      <= '0;
                sh_mode[i]   <= MODE_OFF;
                sh_period[i] <= '0;
                sh_duty[i]   <= '0;
            end
            ff      <= '0;
            pending <= '0;
            tick    <= '0;
            out     <= {CHANNELS{INV}};
        end else begin
            tick <= wrap;
            out  <= raw_c ^ {CHANNELS{INV}};
            for (int i = 0; i < CHANNELS; i++) begin
                count[i] <= (running[i] && !wrap[i]) ? count[i] + CNT_W'(1) : '0;
                if (wrap[i] && (mode[i] == MODE_TOGGLE)) begin
                    ff[i] <= ~ff[i];
                end
                if (accept[i] && (!running[i] || wrap[i])) begin
                    // Idle channel or accept on the wrap itself: take effect right away.
                    mode[i]   <= cfg_mode_e;
                    period[i] <= cfg_period;
                    duty[i]   <= cfg_duty;
                    if (cfg_mode_e != MODE_TOGGLE) begin
                        ff[i] <= 1'b0;
                    end
                end else if (accept[i]) begin
                    // Running channel: hold the request until the current cycle completes.
                    sh_mode[i]   <= cfg_mode_e;
                    sh_period[i] <= cfg_period;
                    sh_duty[i]   <= cfg_duty;
                    pending[i]   <= 1'b1;
                end else if (pending[i] && wrap[i]) begin
                    mode[i]    <= sh_mode[i];
                    period[i]  <= sh_period[i];
                    duty[i]    <= sh_duty[i];
                    pending[i] <= 1'b0;
                    if (sh_mode[i] != MODE_TOGGLE) begin
                        ff[i] <= 1'b0;
                    end
                end
            end
        end
    end

endmodule
